// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: upstream valid/ready, downstream valid/ready,
// flush and occupancy count.
interface pipe_reg_chain_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  // Source/sink side that talks to the chain
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  // The chain itself
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Pipeline register chain with valid/ready backpressure, bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 3,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input logic              clk,
  input logic              rst,
  pipe_reg_chain_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] data_nxt [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;

  // Ready ripples from the output side; an empty stage is always ready
  always_comb begin
    rdy            = '0;
    rdy[DEPTH-1]   = !v_q[DEPTH-1] | bus.out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      rdy[i] = !v_q[i] | rdy[i+1];
    end
  end

  // Next stage contents; data only moves alongside a valid
  always_comb begin
    v_nxt    = v_q;
    data_nxt = data_q;
    if (bus.flush) begin
      v_nxt = '0;
    end else begin
      if (rdy[0]) begin
        v_nxt[0] = bus.in_valid;
        if (bus.in_valid) data_nxt[0] = bus.in_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (rdy[i]) begin
          v_nxt[i] = v_q[i-1];
          if (v_q[i-1]) data_nxt[i] = data_q[i-1];
        end
      end
    end
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_nxt = count_nxt + CW'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= RESET_DATA;
    end else begin
      v_q     <= v_nxt;
      count_q <= count_nxt;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= data_nxt[i];
    end
  end

  assign bus.in_ready  = rdy[0] & !bus.flush;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed scenarios plus random traffic, compared
// against a position-based model of items travelling through the chain.
module tb_pipe_reg_chain;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_reg_chain #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_DATA (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each in-flight word has a position 0..DEPTH-1; index 0 is the oldest
  typedef int pos_q_t[$];
  int               m_pos[$];
  logic [WIDTH-1:0] m_data[$];

  // Positions after one edge: each word advances one slot unless the word
  // ahead blocks it; a word in the last slot leaves when out_ready is high.
  // A leaving word is marked with position DEPTH.
  function automatic pos_q_t moved(input bit ordy);
    pos_q_t np;
    int     limit;
    int     p;
    limit = int'(DEPTH) - 1;
    for (int k = 0; k < m_pos.size(); k++) begin
      if (k == 0 && m_pos[k] == int'(DEPTH) - 1 && ordy) begin
        np.push_back(int'(DEPTH));
      end else begin
        p = m_pos[k] + 1;
        if (p > limit) p = limit;
        np.push_back(p);
        limit = p - 1;
      end
    end
    return np;
  endfunction

  function automatic bit model_in_ready(input bit fl, input bit ordy);
    pos_q_t np;
    np = moved(ordy);
    if (fl) return 1'b0;
    if (np.size() == 0) return 1'b1;
    return np[np.size()-1] > 0;
  endfunction

  task automatic model_edge(input bit fl, input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
    pos_q_t np;
    bit     acc;
    acc = iv && model_in_ready(fl, ordy);
    np  = moved(ordy);
    if (fl) begin
      m_pos.delete();
      m_data.delete();
    end else begin
      if (np.size() > 0 && np[0] == int'(DEPTH)) begin
        void'(np.pop_front());
        void'(m_data.pop_front());
      end
      m_pos = np;
      if (acc) begin
        m_pos.push_back(0);
        m_data.push_back(d);
      end
    end
  endtask

  task automatic check_outputs();
    bit mov;
    mov = (m_pos.size() > 0) && (m_pos[0] == int'(DEPTH) - 1);
    check("out_valid", 32'(bus.out_valid), 32'(mov));
    check("count", 32'(bus.count), 32'(m_pos.size()));
    if (mov) check("out_data", 32'(bus.out_data), 32'(m_data[0]));
  endtask

  // Drive one cycle's inputs, check in_ready before the edge, outputs after it
  task automatic cycle(input bit fl, input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(model_in_ready(fl, ordy)));
    @(posedge clk);
    model_edge(fl, iv, d, ordy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 8'h00, ordy);
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state, before any clock edge
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h00);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Single word latency
    cycle(1'b0, 1'b1, 8'hA5, 1'b1);
    idle(4, 1'b1);

    // Streaming 1..10
    for (int k = 1; k <= 10; k++) cycle(1'b0, 1'b1, 8'(k), 1'b1);
    idle(4, 1'b1);

    // Backpressure fill: 44 held until the chain drains
    cycle(1'b0, 1'b1, 8'd11, 1'b0);
    cycle(1'b0, 1'b1, 8'd22, 1'b0);
    cycle(1'b0, 1'b1, 8'd33, 1'b0);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b0, 1'b1, 8'd44, 1'b0);
    cycle(1'b0, 1'b1, 8'd44, 1'b0);
    check("full_hold_data", 32'(bus.out_data), 32'd11);
    cycle(1'b0, 1'b1, 8'd44, 1'b1);
    idle(5, 1'b1);

    // Bubble collapse
    cycle(1'b0, 1'b1, 8'h31, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h32, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h33, 1'b0);
    idle(3, 1'b0);
    check("collapse_count", 32'(bus.count), 32'd3);
    idle(5, 1'b1);

    // Flush a full chain while offering 8'hFF
    cycle(1'b0, 1'b1, 8'h41, 1'b0);
    cycle(1'b0, 1'b1, 8'h42, 1'b0);
    cycle(1'b0, 1'b1, 8'h43, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    check("flush_count", 32'(bus.count), 32'd0);
    idle(5, 1'b1);

    // Asynchronous reset with two words in flight
    cycle(1'b0, 1'b1, 8'h51, 1'b0);
    cycle(1'b0, 1'b1, 8'h52, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'h00);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    m_pos.delete();
    m_data.delete();
    #1;
    rst = 1'b1;
    cycle(1'b0, 1'b1, 8'hC3, 1'b1);
    idle(4, 1'b1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
            8'($urandom), ($urandom_range(0, 3) != 0));
    end
    idle(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised pipeline register chain of DEPTH stages, each WIDTH bits wide, with a valid/ready handshake on both ends.
- Successor to the single-bit async-reset D flip-flop: it adds width, depth, stall/backpressure with bubble collapsing, synchronous flush, and an occupancy count.
- Used as a timing-closure slice between datapath blocks, wherever a retimed path must still honour backpressure.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 3, number of register stages (>=1)
RESET_DATA, 0, value loaded into every data register on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all stage valids
in_valid  input  1  upstream data valid
in_data  input  WIDTH  upstream data
in_ready  output  1  chain can accept in_data this cycle
out_valid  output  1  stage DEPTH-1 holds valid data
out_data  output  WIDTH  stage DEPTH-1 data
out_ready  input  1  downstream accepts out_data this cycle
count  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- State: per stage i (0 = input side, DEPTH-1 = output side): data[i] (WIDTH bits), v[i] (1 bit).
- Reset (rst=0, asynchronous): all v[i]=0, all data[i]=RESET_DATA, count=0, out_valid=0, out_data=RESET_DATA. Reset has priority over everything.
- Release: leaving reset needs no clock edge. The first transfer occurs on the first rising edge with rst=1.
- Ready chain (combinational, no registered ready):
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready
  - rdy[i] = !v[i] | rdy[i+1]
  - in_ready = rdy[0] & !flush
- Stage update at posedge when rdy[i]=1:
  - stage 0: v[0] <= in_valid & !flush; data[0] <= in_data when in_valid.
  - stage i>0: v[i] <= v[i-1]; data[i] <= data[i-1] when v[i-1].
- Stage hold: when rdy[i]=0, the stage holds both data and valid.
- Bubble collapsing: an empty stage always accepts, even if downstream is stalled. A stalled chain therefore fills completely before in_ready drops.
- Data registers are not updated when the incoming valid is 0. Stale data is permitted; only the valid bit governs.
- Latency: DEPTH cycles from an in_valid&in_ready edge to out_valid, with no stalls. Throughput is 1 per cycle.
- Transfers: upstream transfer = in_valid&in_ready at posedge; downstream transfer = out_valid&out_ready at posedge. Simultaneous transfers on a full chain are legal, and occupancy is unchanged.
- Flush (synchronous, priority over in_valid and out_ready): next edge all v[i]=0 and count=0; data registers unchanged.
  - While flush=1, in_ready=0 and no input is accepted.
  - out_valid may still be 1 during the flush cycle. Downstream must ignore a transfer in that cycle; the stage is cleared regardless.
- count: registered; equals the popcount of v[] after each edge, ranging 0..DEPTH.
- Full: count==DEPTH and out_ready=0 -> in_ready=0.
- Empty: count==0 -> out_valid=0, in_ready=1 (unless flush).
- Reset mid-operation: all in-flight data is discarded immediately; no partial outputs are produced.
- Protocol rule: upstream must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.

Test Plan:
1. Reset with DEPTH=3, WIDTH=8: drive rst=0 -> out_valid=0, out_data=8'h00, count=0, in_ready=1. Release rst and present 8'hA5 for one cycle with out_ready=1 -> out_valid=1, out_data=8'hA5 exactly 3 edges later, for one cycle.
2. Streaming: inputs 1,2,3,...,10 on consecutive cycles, out_ready=1 -> outputs 1..10 in order on consecutive cycles starting at edge 3; count=3 at steady state; no gaps.
3. Backpressure/fill: out_ready=0, present 4 words 11,22,33,44 -> 11,22,33 accepted, in_ready=0 after the 3rd edge, count=3, out_data=11 held. Raise out_ready -> 11,22,33,44 emitted in order, nothing lost or duplicated.
4. Bubble collapse: inputs with gaps (valid at cycles 0,2,4), out_ready=0 from cycle 1 -> the chain compacts to count=3 with no idle stages between valids; order is preserved on release.
5. Flush: chain full (count=3), assert flush with in_valid=1, in_data=8'hFF -> in_ready=0 that cycle; next edge count=0, out_valid=0; 8'hFF never appears at the output.
6. Async reset mid-stream: pulse rst low between clock edges while count=2 -> out_valid and count drop to 0 immediately, without waiting for a clock edge. After release, a new word emerges after 3 edges.
